// File: rtl/ysyx_201979054_burst_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_201979054_burst_ctrl
//
// Turns one cache-line request (refill or write-back) into BEATS single-beat
// AXI4-Lite transactions at consecutive word addresses. Only one transaction
// is ever outstanding. The next AR/AW is issued only after the previous R/B
// has been accepted.
//
// Ports
//   clk, arstn          : clock (rising edge), asynchronous active-low reset
//   i_start, i_write    : burst request and direction (1 = write-back)
//   i_base_addr         : line address; offset bits inside the line are ignored
//   i_wdata             : write word for beat o_beat_idx (held while writing)
//   o_beat_idx          : current beat; during o_rdata_valid, the beat of o_rdata
//   o_rdata/o_rdata_valid : refill word and its 1-cycle strobe
//   o_busy, o_done      : not-idle flag, 1-cycle end-of-burst pulse
//   o_error             : sticky non-OKAY response flag, cleared by a new start
//   AR/R/AW/W/B         : AXI4-Lite master channels
// ----------------------------------------------------------------------------
module ysyx_201979054_burst_ctrl #(
  parameter int BEATS  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       i_start,
  input  logic                       i_write,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [$clog2(BEATS)-1:0]   o_beat_idx,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_rdata_valid,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [ADDR_W-1:0]          o_araddr,
  output logic                       o_arvalid,
  input  logic                       i_arready,
  input  logic [DATA_W-1:0]          i_rdata,
  input  logic [1:0]                 i_rresp,
  input  logic                       i_rvalid,
  output logic                       o_rready,
  output logic [ADDR_W-1:0]          o_awaddr,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [DATA_W-1:0]          o_wdata,
  output logic [DATA_W/8-1:0]        o_wstrb,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  input  logic [1:0]                 i_bresp,
  input  logic                       i_bvalid,
  output logic                       o_bready
);

  localparam int BYTES = DATA_W / 8;
  localparam int BOFF  = $clog2(BYTES);
  localparam int IDX_W = $clog2(BEATS);
  localparam int OFF   = $clog2(BEATS * BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [ADDR_W-OFF-1:0] r_base;
  logic                  r_aw_acc;
  logic                  r_w_acc;
  logic                  r_error;
  logic                  r_rdata_valid;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_last;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_unused;

  // Offset bits within the line are never used; the address is rebuilt from
  // the line base and the beat counter.
  assign w_unused  = ^i_base_addr[OFF-1:0];

  assign w_last    = (r_idx == IDX_W'(BEATS - 1));
  // A channel counts as accepted if it was accepted earlier in this beat or
  // its ready is seen now (its valid is high whenever its flag is clear).
  assign w_aw_done = r_aw_acc | i_awready;
  assign w_w_done  = r_w_acc  | i_wready;

  // Counter is spliced below the line base, so it can never carry into it.
  always_comb begin
    w_addr                = '0;
    w_addr[ADDR_W-1:OFF]  = r_base;
    w_addr[OFF-1:BOFF]    = r_idx;
  end

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = i_write ? S_WR_REQ : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        if (i_arready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (i_rvalid) w_next = w_last ? S_DONE : S_RD_ADDR;
      end
      S_WR_REQ: begin
        if (w_aw_done && w_w_done) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (i_bvalid) w_next = w_last ? S_DONE : S_WR_REQ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state only, so no valid depends on a ready
  always_comb begin
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    o_done    = 1'b0;
    o_busy    = 1'b1;
    case (r_state)
      S_IDLE:    o_busy = 1'b0;
      S_RD_ADDR: o_arvalid = 1'b1;
      S_RD_DATA: o_rready = 1'b1;
      S_WR_REQ: begin
        o_awvalid = ~r_aw_acc;
        o_wvalid  = ~r_w_acc;
      end
      S_WR_RESP: o_bready = 1'b1;
      S_DONE:    o_done = 1'b1;
      default:   o_busy = 1'b0;
    endcase
  end

  // Beat counter, line base, accept flags, read data and error flag
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_idx         <= '0;
      r_rd_idx      <= '0;
      r_base        <= '0;
      r_aw_acc      <= 1'b0;
      r_w_acc       <= 1'b0;
      r_error       <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_rdata_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base   <= i_base_addr[ADDR_W-1:OFF];
            r_idx    <= '0;
            r_error  <= 1'b0;
            r_aw_acc <= 1'b0;
            r_w_acc  <= 1'b0;
          end
        end
        S_RD_DATA: begin
          if (i_rvalid) begin
            r_rdata       <= i_rdata;
            r_rdata_valid <= 1'b1;
            // Keep the beat of this word for the strobe cycle; r_idx moves on.
            r_rd_idx      <= r_idx;
            if (i_rresp != 2'b00) r_error <= 1'b1;
            if (!w_last) r_idx <= r_idx + 1'b1;
          end
        end
        S_WR_REQ: begin
          if (w_aw_done && w_w_done) begin
            r_aw_acc <= 1'b0;
            r_w_acc  <= 1'b0;
          end else begin
            r_aw_acc <= w_aw_done;
            r_w_acc  <= w_w_done;
          end
        end
        S_WR_RESP: begin
          if (i_bvalid) begin
            if (i_bresp != 2'b00) r_error <= 1'b1;
            if (!w_last) r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // During the read strobe show the beat the word belongs to.
  assign o_beat_idx    = r_rdata_valid ? r_rd_idx : r_idx;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_error       = r_error;
  assign o_araddr      = w_addr;
  assign o_awaddr      = w_addr;
  assign o_wdata       = i_wdata;
  assign o_wstrb       = '1;

endmodule

// File: tb/tb_ysyx_201979054_burst_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_201979054_burst_ctrl. A behavioural AXI4-Lite slave drives
// random data and configurable ready/valid delays; expected addresses, data,
// counts and burst lengths come from the line-burst rules computed here.
// ----------------------------------------------------------------------------
module tb_ysyx_201979054_burst_ctrl;
  localparam int BEATS  = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              arstn;
  logic              i_start, i_write;
  logic [ADDR_W-1:0] i_base_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [3:0]        o_beat_idx;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rdata_valid, o_busy, o_done, o_error;
  logic [ADDR_W-1:0] o_araddr, o_awaddr;
  logic              o_arvalid, i_arready;
  logic [DATA_W-1:0] i_rdata;
  logic [1:0]        i_rresp;
  logic              i_rvalid, o_rready;
  logic              o_awvalid, i_awready;
  logic [DATA_W-1:0] o_wdata;
  logic [3:0]        o_wstrb;
  logic              o_wvalid, i_wready;
  logic [1:0]        i_bresp;
  logic              i_bvalid, o_bready;

  ysyx_201979054_burst_ctrl #(.BEATS(BEATS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .arstn(arstn), .i_start(i_start), .i_write(i_write),
    .i_base_addr(i_base_addr), .i_wdata(i_wdata), .o_beat_idx(o_beat_idx),
    .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations of the last burst
  logic [31:0] q_araddr[$], q_awaddr[$], q_wdata[$], q_rsent[$], q_rdata[$];
  int          q_ridx[$];
  int          n_aw, n_w, n_b, n_same, n_awonly, n_viol, done_cyc;
  bit          err_done, err_c1, busy_c1;
  logic [31:0] wmem [BEATS];

  // Line-aligned base plus word offset
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return (base & ~32'(BEATS * 4 - 1)) + 32'(i * 4);
  endfunction

  task automatic clear_slave();
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
  endtask

  // Issues one burst and plays the slave until o_done (or a cycle bound).
  task automatic run_burst(input bit wr, input logic [31:0] base, input int aw_lag,
                           input int w_lag, input bit rnd, input int err_beat,
                           input bit start_mid, input bit start_done);
    int cyc, rd_beat, wr_beat, aw_cnt, w_cnt;
    bit r_pend, b_pend, aw_got, w_got, pulsed;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_hs_d, b_hs_d;
    bit ar_wait, aw_wait, w_wait;
    logic [31:0] ar_prev, aw_prev, w_prev;
    q_araddr.delete(); q_awaddr.delete(); q_wdata.delete();
    q_rsent.delete(); q_rdata.delete(); q_ridx.delete();
    n_aw = 0; n_w = 0; n_b = 0; n_same = 0; n_awonly = 0; n_viol = 0;
    done_cyc = -1; err_done = 1'b0; err_c1 = 1'b1; busy_c1 = 1'b0;
    rd_beat = 0; wr_beat = 0; aw_cnt = 0; w_cnt = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; pulsed = 0;
    r_hs_d = 0; b_hs_d = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
    ar_prev = '0; aw_prev = '0; w_prev = '0;
    @(negedge clk);
    clear_slave();
    i_start = 1'b1; i_write = wr; i_base_addr = base;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0; i_write = wr; i_base_addr = base;
      if (start_mid && !pulsed && (wr ? wr_beat : rd_beat) == 3) begin
        i_start = 1'b1; i_write = !wr; i_base_addr = ~base; pulsed = 1;
      end
      if (cyc == 1) begin err_c1 = o_error; busy_c1 = o_busy; end
      if (o_rdata_valid) begin
        q_ridx.push_back(int'(o_beat_idx));
        q_rdata.push_back(o_rdata);
      end
      if (ar_wait && (!o_arvalid || o_araddr !== ar_prev)) n_viol++;
      if (aw_wait && (!o_awvalid || o_awaddr !== aw_prev)) n_viol++;
      if (w_wait && (!o_wvalid || o_wdata !== w_prev)) n_viol++;
      if (o_done) begin
        done_cyc = cyc;
        err_done = o_error;
        clear_slave();
        i_start = start_done; i_write = !wr;
        break;
      end
      if (r_hs_d) i_rvalid = 1'b0;
      if (b_hs_d) i_bvalid = 1'b0;
      i_wdata   = wmem[o_beat_idx];
      i_arready = o_arvalid && (!rnd || $urandom_range(0, 1) == 1);
      i_awready = o_awvalid && (aw_cnt >= aw_lag) && (!rnd || $urandom_range(0, 1) == 1);
      i_wready  = o_wvalid && (w_cnt >= w_lag) && (!rnd || $urandom_range(0, 1) == 1);
      if (r_pend && !i_rvalid && (!rnd || $urandom_range(0, 1) == 1)) begin
        i_rvalid = 1'b1;
        i_rdata  = $urandom;
        i_rresp  = (rd_beat == err_beat) ? 2'b10 : 2'b00;
        q_rsent.push_back(i_rdata);
      end
      if (b_pend && !i_bvalid && (!rnd || $urandom_range(0, 1) == 1)) begin
        i_bvalid = 1'b1;
        i_bresp  = (wr_beat == err_beat) ? 2'b10 : 2'b00;
      end
      ar_hs = o_arvalid && i_arready;
      r_hs  = i_rvalid && o_rready;
      aw_hs = o_awvalid && i_awready;
      w_hs  = o_wvalid && i_wready;
      b_hs  = i_bvalid && o_bready;
      if (ar_hs && r_pend) n_viol++;
      if ((aw_hs || w_hs) && b_pend) n_viol++;
      if (r_hs) begin r_pend = 0; rd_beat++; end
      if (b_hs) begin b_pend = 0; wr_beat++; n_b++; end
      if (ar_hs) begin r_pend = 1; q_araddr.push_back(o_araddr); end
      if (aw_hs) begin n_aw++; q_awaddr.push_back(o_awaddr); aw_got = 1; aw_cnt = 0; end
      else if (o_awvalid) aw_cnt++;
      if (w_hs) begin n_w++; q_wdata.push_back(o_wdata); w_got = 1; w_cnt = 0; end
      else if (o_wvalid) w_cnt++;
      if (aw_hs && w_hs) n_same++;
      if (o_awvalid && !o_wvalid) n_awonly++;
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      r_hs_d = r_hs; b_hs_d = b_hs;
      ar_wait = o_arvalid && !i_arready; ar_prev = o_araddr;
      aw_wait = o_awvalid && !i_awready; aw_prev = o_awaddr;
      w_wait  = o_wvalid && !i_wready;   w_prev  = o_wdata;
    end
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    #1;
    ctl = {o_busy, o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_done, o_rdata_valid};
    checks++;
    if (ctl !== 8'h00 || o_error !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b err %b expected 00000000 err 0", ctl, o_error);
    end
    checks++;
    if (o_rdata !== '0 || o_araddr !== '0 || o_awaddr !== '0 || o_beat_idx !== 4'd0) begin
      errors++; $display("FAIL reset_data: got rdata %h araddr %h awaddr %h idx %0d expected all 0",
                         o_rdata, o_araddr, o_awaddr, o_beat_idx);
    end
    checks++;
    if (o_wstrb !== 4'hF) begin
      errors++; $display("FAIL reset_wstrb: got %h expected f", o_wstrb);
    end
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy %b done %b expected 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_refill();
    logic [31:0] base;
    base = 32'h8000_1234;
    run_burst(1'b0, base, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (done_cyc != 2 * BEATS + 1) begin
      errors++; $display("FAIL refill_done_cycle: got %0d expected %0d", done_cyc, 2 * BEATS + 1);
    end
    checks++;
    if (busy_c1 !== 1'b1) begin errors++; $display("FAIL refill_busy: got %b expected 1", busy_c1); end
    checks++;
    if (q_araddr.size() != BEATS) begin
      errors++; $display("FAIL refill_ar_count: got %0d expected %0d", q_araddr.size(), BEATS);
    end
    for (int i = 0; i < q_araddr.size() && i < BEATS; i++) begin
      checks++;
      if (q_araddr[i] !== exp_addr(base, i)) begin
        errors++; $display("FAIL refill_araddr[%0d]: got %h expected %h", i, q_araddr[i], exp_addr(base, i));
      end
    end
    checks++;
    if (q_ridx.size() != BEATS || q_rsent.size() != BEATS) begin
      errors++; $display("FAIL refill_pulses: got %0d expected %0d", q_ridx.size(), BEATS);
    end
    for (int i = 0; i < q_ridx.size() && i < q_rsent.size(); i++) begin
      checks++;
      if (q_ridx[i] != i || q_rdata[i] !== q_rsent[i]) begin
        errors++; $display("FAIL refill_rdata[%0d]: got idx %0d data %h expected idx %0d data %h",
                           i, q_ridx[i], q_rdata[i], i, q_rsent[i]);
      end
    end
    checks++;
    if (err_done !== 1'b0 || n_viol != 0) begin
      errors++; $display("FAIL refill_err_proto: got err %b viol %0d expected 0 0", err_done, n_viol);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL refill_after_done: got busy %b done %b expected 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_wb_skew();
    logic [31:0] base;
    for (int i = 0; i < BEATS; i++) wmem[i] = $urandom;
    base = $urandom;
    run_burst(1'b1, base, 3, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (n_aw != BEATS || n_w != BEATS || n_b != BEATS) begin
      errors++; $display("FAIL skew_counts: got aw %0d w %0d b %0d expected %0d each", n_aw, n_w, n_b, BEATS);
    end
    for (int i = 0; i < q_awaddr.size() && i < BEATS; i++) begin
      checks++;
      if (q_awaddr[i] !== exp_addr(base, i) || q_wdata[i] !== wmem[i]) begin
        errors++; $display("FAIL skew_beat[%0d]: got addr %h data %h expected addr %h data %h",
                           i, q_awaddr[i], q_wdata[i], exp_addr(base, i), wmem[i]);
      end
    end
    checks++;
    if (n_awonly != 3 * BEATS) begin
      errors++; $display("FAIL skew_aw_hold: got %0d cycles expected %0d", n_awonly, 3 * BEATS);
    end
    checks++;
    if (done_cyc != 5 * BEATS + 1) begin
      errors++; $display("FAIL skew_done_cycle: got %0d expected %0d", done_cyc, 5 * BEATS + 1);
    end
    checks++;
    if (n_viol != 0 || err_done !== 1'b0) begin
      errors++; $display("FAIL skew_proto: got viol %0d err %b expected 0 0", n_viol, err_done);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] base;
    for (int i = 0; i < BEATS; i++) wmem[i] = $urandom;
    base = $urandom;
    run_burst(1'b1, base, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (n_same != BEATS || n_awonly != 0) begin
      errors++; $display("FAIL same_drop: got same %0d awonly %0d expected %0d 0", n_same, n_awonly, BEATS);
    end
    checks++;
    if (n_b != BEATS || done_cyc != 2 * BEATS + 1) begin
      errors++; $display("FAIL same_len: got b %0d done %0d expected %0d %0d", n_b, done_cyc, BEATS, 2 * BEATS + 1);
    end
    checks++;
    if (q_wdata.size() != BEATS || q_wdata[BEATS-1] !== wmem[BEATS-1]) begin
      errors++; $display("FAIL same_wdata: got n %0d expected %0d", q_wdata.size(), BEATS);
    end
  endtask

  task automatic test_error();
    run_burst(1'b0, $urandom, 0, 0, 1'b0, 5, 1'b0, 1'b0);
    checks++;
    if (q_ridx.size() != BEATS || done_cyc != 2 * BEATS + 1) begin
      errors++; $display("FAIL err_complete: got beats %0d done %0d expected %0d %0d",
                         q_ridx.size(), done_cyc, BEATS, 2 * BEATS + 1);
    end
    checks++;
    if (err_done !== 1'b1) begin errors++; $display("FAIL err_at_done: got %b expected 1", err_done); end
    @(negedge clk);
    checks++;
    if (o_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", o_error); end
    for (int i = 0; i < BEATS; i++) wmem[i] = $urandom;
    run_burst(1'b1, $urandom, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (err_c1 !== 1'b0 || err_done !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b/%b expected 0/0", err_c1, err_done);
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] base;
    int bad;
    base = $urandom;
    run_burst(1'b0, base, 0, 0, 1'b0, -1, 1'b1, 1'b1);
    checks++;
    if (done_cyc != 2 * BEATS + 1 || q_araddr.size() != BEATS) begin
      errors++; $display("FAIL busy_len: got done %0d ar %0d expected %0d %0d",
                         done_cyc, q_araddr.size(), 2 * BEATS + 1, BEATS);
    end
    bad = 0;
    for (int i = 0; i < q_araddr.size(); i++) if (q_araddr[i] !== exp_addr(base, i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_addrs: got %0d wrong expected 0", bad); end
    @(negedge clk);
    i_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_busy !== 1'b0 || o_arvalid !== 1'b0 || o_awvalid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_stays_idle: got %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] base;
    logic [5:0]  ctl;
    int k;
    @(negedge clk);
    clear_slave();
    i_start = 1'b1; i_write = 1'b0; i_base_addr = $urandom;
    @(negedge clk);
    i_start = 1'b0;
    k = 0;
    while (k < 200) begin
      i_arready = o_arvalid;
      if (o_rready && o_beat_idx == 4'd7) break;
      i_rvalid = o_rready;
      i_rdata  = $urandom;
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 200) begin errors++; $display("FAIL rstmid_reach: got timeout expected beat 7"); end
    i_rvalid = 1'b1; i_rdata = $urandom;
    #1 arstn = 1'b0;
    #1;
    ctl = {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_busy};
    checks++;
    if (ctl !== 6'b0 || o_beat_idx !== 4'd0 || o_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_now: got ctl %b idx %0d expected 000000 idx 0", ctl, o_beat_idx);
    end
    @(negedge clk);
    checks++;
    if (o_rdata_valid !== 1'b0 || o_rdata !== '0) begin
      errors++; $display("FAIL rstmid_no_hs: got valid %b data %h expected 0 0", o_rdata_valid, o_rdata);
    end
    clear_slave();
    arstn = 1'b1;
    base = $urandom;
    run_burst(1'b0, base, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (q_araddr.size() == 0 || q_araddr[0] !== exp_addr(base, 0) || done_cyc != 2 * BEATS + 1) begin
      errors++; $display("FAIL rstmid_restart: got first %h done %0d expected %h %0d",
                         (q_araddr.size() != 0) ? q_araddr[0] : 32'h0, done_cyc, exp_addr(base, 0), 2 * BEATS + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    bit wr;
    int eb, bad;
    for (int t = 0; t < 6; t++) begin
      wr = $urandom_range(0, 1);
      base = $urandom;
      eb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, BEATS - 1)) : -1;
      for (int i = 0; i < BEATS; i++) wmem[i] = $urandom;
      run_burst(wr, base, 0, 0, 1'b1, eb, 1'b0, 1'b0);
      bad = 0;
      if (wr) begin
        if (q_awaddr.size() != BEATS || q_wdata.size() != BEATS || n_b != BEATS) bad++;
        for (int i = 0; i < q_awaddr.size() && i < q_wdata.size(); i++)
          if (q_awaddr[i] !== exp_addr(base, i) || q_wdata[i] !== wmem[i]) bad++;
      end else begin
        if (q_araddr.size() != BEATS || q_ridx.size() != BEATS || q_rsent.size() != BEATS) bad++;
        for (int i = 0; i < q_araddr.size(); i++) if (q_araddr[i] !== exp_addr(base, i)) bad++;
        for (int i = 0; i < q_ridx.size() && i < q_rsent.size(); i++)
          if (q_ridx[i] != i || q_rdata[i] !== q_rsent[i]) bad++;
      end
      checks++;
      if (bad != 0 || done_cyc < 0) begin
        errors++; $display("FAIL rand%0d_beats: got %0d bad beats done %0d expected 0 bad and done", t, bad, done_cyc);
      end
      checks++;
      if (err_done !== (eb >= 0) || n_viol != 0) begin
        errors++; $display("FAIL rand%0d_err: got err %b viol %0d expected err %b viol 0", t, err_done, n_viol, eb >= 0);
      end
    end
  endtask

  initial begin
    arstn = 1'b0;
    i_start = 1'b0; i_write = 1'b0; i_base_addr = '0; i_wdata = '0;
    clear_slave();
    for (int i = 0; i < BEATS; i++) wmem[i] = '0;
    test_reset();
    test_refill();
    test_wb_skew();
    test_same_cycle();
    test_error();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
